// File: rtl/sr_zbb_top.sv
// sr_zbb_top: single-cycle RV32 teaching core with the Zbb bit-manipulation subset.
// Contains a clock divider, the CPU (pc, decoder, register file, ALU) and a word-addressed
// instruction ROM. A debug port exposes a register, or the pc when regAddr is 0.
// Optional feature macro: ZBB_EN. When it is defined, the Zbb instructions are decoded.
// When it is undefined, Zbb encodings behave as unknown instructions.
module sr_zbb_top #(
    parameter int    ROM_DEPTH  = 64,
    parameter string ROM_FILE   = "program.hex",
    parameter int    DIV_SHIFT  = 16,
    parameter int    DIV_BYPASS = 0
) (
    input  logic        clkIn,
    input  logic        rst_n,
    input  logic [3:0]  clkDevide,
    input  logic        clkEnable,
    output logic        clk,
    input  logic [4:0]  regAddr,
    output logic [31:0] regData
);

    localparam int AW = $clog2(ROM_DEPTH);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [31:0] cntr;
    logic [4:0]  tap;
    logic [31:0] rom [ROM_DEPTH];
    logic [31:0] rf [1:31];
    logic [31:0] pc;
    logic [31:0] instr;
    logic [29:0] word_idx;
    logic        in_range;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm12;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_b;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        wr_en;
    logic        taken;
    logic        unused_pc_lsb;

`ifdef ZBB_EN
    function automatic logic [31:0] count_lz(input logic [31:0] v);
        logic [31:0] n;
        n = 32'd32;
        for (int i = 0; i < 32; i++) if (v[i]) n = 32'(31 - i);
        return n;
    endfunction

    function automatic logic [31:0] count_tz(input logic [31:0] v);
        logic [31:0] n;
        n = 32'd32;
        for (int i = 31; i >= 0; i--) if (v[i]) n = 32'(i);
        return n;
    endfunction

    function automatic logic [31:0] count_pop(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + {31'b0, v[i]};
        return n;
    endfunction

    function automatic logic [31:0] rot_left(input logic [31:0] v, input logic [4:0] s);
        logic [63:0] t;
        t = {v, v} << s;
        return t[63:32];
    endfunction

    function automatic logic [31:0] rot_right(input logic [31:0] v, input logic [4:0] s);
        logic [63:0] t;
        t = {v, v} >> s;
        return t[31:0];
    endfunction

    function automatic logic [31:0] or_combine(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{|v[8*i +: 8]}};
        return r;
    endfunction
`endif

    // Divider counter free-runs on the board clock while enabled
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) cntr <= '0;
        else if (clkEnable) cntr <= cntr + 32'd1;
    end

    assign tap = 5'(DIV_SHIFT) + {1'b0, clkDevide};
    assign clk = (DIV_BYPASS != 0) ? clkIn : cntr[tap];

    assign word_idx      = pc[31:2];
    assign in_range      = {2'b00, word_idx} < 32'(ROM_DEPTH);
    assign instr         = in_range ? rom[word_idx[AW-1:0]] : '0;
    assign unused_pc_lsb = ^pc[1:0];

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];
    assign imm12  = instr[31:20];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    assign a = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign b = (rs2 == 5'd0) ? '0 : rf[rs2];

    // Decode and execute the current instruction: produce the write-back value and branch decision
    always_comb begin
        result = '0;
        wr_en  = 1'b0;
        taken  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                result = imm_u;
                wr_en  = 1'b1;
            end
            OPC_BRANCH: begin
                if (f3 == 3'b000) taken = (a == b);
                else if (f3 == 3'b001) taken = (a != b);
            end
            OPC_OP: begin
                wr_en = 1'b1;
                case ({f7, f3})
                    {7'b0000000, 3'b000}: result = a + b;
                    {7'b0100000, 3'b000}: result = a - b;
                    {7'b0000000, 3'b110}: result = a | b;
                    {7'b0000000, 3'b101}: result = a >> b[4:0];
                    {7'b0000000, 3'b011}: result = {31'b0, a < b};
`ifdef ZBB_EN
                    {7'b0100000, 3'b111}: result = a & ~b;
                    {7'b0100000, 3'b110}: result = a | ~b;
                    {7'b0100000, 3'b100}: result = ~(a ^ b);
                    {7'b0000101, 3'b100}: result = ($signed(a) < $signed(b)) ? a : b;
                    {7'b0000101, 3'b101}: result = (a < b) ? a : b;
                    {7'b0000101, 3'b110}: result = ($signed(a) < $signed(b)) ? b : a;
                    {7'b0000101, 3'b111}: result = (a < b) ? b : a;
                    {7'b0110000, 3'b001}: result = rot_left(a, b[4:0]);
                    {7'b0110000, 3'b101}: result = rot_right(a, b[4:0]);
                    {7'b0000100, 3'b100}: begin
                        result = {16'b0, a[15:0]};
                        wr_en  = (rs2 == 5'd0);
                    end
`endif
                    default: wr_en = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                if (f3 == 3'b000) begin
                    result = a + imm_i;
                    wr_en  = 1'b1;
                end
`ifdef ZBB_EN
                else if (f3 == 3'b001) begin
                    wr_en = 1'b1;
                    case (imm12)
                        12'h600: result = count_lz(a);
                        12'h601: result = count_tz(a);
                        12'h602: result = count_pop(a);
                        12'h604: result = {{24{a[7]}}, a[7:0]};
                        12'h605: result = {{16{a[15]}}, a[15:0]};
                        default: wr_en = 1'b0;
                    endcase
                end else if (f3 == 3'b101) begin
                    wr_en = 1'b1;
                    if (imm12[11:5] == 7'b0110000) result = rot_right(a, imm12[4:0]);
                    else if (imm12 == 12'h287) result = or_combine(a);
                    else if (imm12 == 12'h698) result = {a[7:0], a[15:8], a[23:16], a[31:24]};
                    else wr_en = 1'b0;
                end
`endif
            end
            default: ;
        endcase
    end

    // Architectural state update: pc advance or branch, and register write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            for (int i = 1; i < 32; i++) rf[i] <= '0;
        end else begin
            pc <= taken ? pc + imm_b : pc + 32'd4;
            if (wr_en && rd != 5'd0) rf[rd] <= result;
        end
    end

    assign regData = (regAddr != 5'd0) ? rf[regAddr] : pc;

endmodule

// File: tb/tb_sr_zbb_top.sv
// tb_sr_zbb_top: directed test of sr_zbb_top with a hand-assembled program placed in the ROM,
// plus a second instance exercising the clock divider.
module tb_sr_zbb_top;

`ifdef ZBB_EN
    localparam bit ZBB = 1'b1;
`else
    localparam bit ZBB = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [3:0]  clk_devide;
    logic        clk_enable;
    logic        cpu_clk;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;

    logic        div_rst_n;
    logic        div_enable;
    logic        div_clk;
    logic [4:0]  div_reg_addr;
    logic [31:0] div_reg_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] prog [40];

    always #5 clk_in = ~clk_in;

    sr_zbb_top #(.ROM_DEPTH(64), .ROM_FILE(""), .DIV_SHIFT(16), .DIV_BYPASS(1)) dut (
        .clkIn(clk_in), .rst_n(rst_n), .clkDevide(clk_devide), .clkEnable(clk_enable),
        .clk(cpu_clk), .regAddr(reg_addr), .regData(reg_data)
    );

    sr_zbb_top #(.ROM_DEPTH(64), .ROM_FILE(""), .DIV_SHIFT(0), .DIV_BYPASS(0)) u_div (
        .clkIn(clk_in), .rst_n(div_rst_n), .clkDevide(4'd1), .clkEnable(div_enable),
        .clk(div_clk), .regAddr(div_reg_addr), .regData(div_reg_data)
    );

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] lui(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] btype(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] addr);
        reg_addr = addr;
        #1;
    endtask

    task automatic checkReg(input string tag, input logic [4:0] addr, input logic [31:0] expected);
        applyStimulus(addr);
        checkOutput(tag, reg_data, expected);
    endtask

    initial begin
        logic [5:0] pat;

        rst_n        = 1'b0;
        div_rst_n    = 1'b0;
        clk_devide   = 4'd0;
        clk_enable   = 1'b1;
        div_enable   = 1'b0;
        reg_addr     = 5'd0;
        div_reg_addr = 5'd0;

        prog[0]  = lui(20'hB92F0, 5'd1);
        prog[1]  = itype(12'h4A1, 5'd1, 3'b000, 5'd1);
        prog[2]  = lui(20'h40AC9, 5'd2);
        prog[3]  = itype(12'h810, 5'd2, 3'b000, 5'd2);
        prog[4]  = lui(20'h0001D, 5'd7);
        prog[5]  = lui(20'h00123, 5'd19);
        prog[6]  = itype(12'h400, 5'd19, 3'b000, 5'd19);
        prog[7]  = itype(12'h004, 5'd0, 3'b000, 5'd21);
        prog[8]  = rtype(7'b0100000, 5'd2, 5'd1, 3'b111, 5'd3);
        prog[9]  = rtype(7'b0100000, 5'd2, 5'd1, 3'b110, 5'd4);
        prog[10] = rtype(7'b0100000, 5'd2, 5'd1, 3'b100, 5'd5);
        prog[11] = itype(12'h600, 5'd2, 3'b001, 5'd6);
        prog[12] = itype(12'h601, 5'd7, 3'b001, 5'd8);
        prog[13] = itype(12'h602, 5'd1, 3'b001, 5'd9);
        prog[14] = itype(12'h600, 5'd0, 3'b001, 5'd10);
        prog[15] = rtype(7'b0000101, 5'd2, 5'd1, 3'b110, 5'd11);
        prog[16] = rtype(7'b0000101, 5'd2, 5'd1, 3'b111, 5'd12);
        prog[17] = rtype(7'b0000101, 5'd2, 5'd1, 3'b100, 5'd13);
        prog[18] = rtype(7'b0000101, 5'd2, 5'd1, 3'b101, 5'd14);
        prog[19] = itype(12'h604, 5'd1, 3'b001, 5'd15);
        prog[20] = itype(12'h605, 5'd1, 3'b001, 5'd16);
        prog[21] = rtype(7'b0000100, 5'd0, 5'd1, 3'b100, 5'd17);
        prog[22] = itype(12'h698, 5'd1, 3'b101, 5'd18);
        prog[23] = itype(12'h287, 5'd19, 3'b101, 5'd20);
        prog[24] = rtype(7'b0110000, 5'd21, 5'd1, 3'b001, 5'd22);
        prog[25] = rtype(7'b0110000, 5'd21, 5'd1, 3'b101, 5'd23);
        prog[26] = itype(12'h604, 5'd1, 3'b101, 5'd24);
        prog[27] = rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd25);
        prog[28] = rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd25);
        prog[29] = rtype(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd26);
        prog[30] = rtype(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd27);
        prog[31] = rtype(7'b0000000, 5'd21, 5'd1, 3'b101, 5'd28);
        prog[32] = rtype(7'b0000000, 5'd1, 5'd2, 3'b011, 5'd29);
        prog[33] = itype(12'h000, 5'd0, 3'b000, 5'd30);
        prog[34] = itype(12'h003, 5'd0, 3'b000, 5'd31);
        prog[35] = itype(12'h001, 5'd30, 3'b000, 5'd30);
        prog[36] = btype(13'h1FFC, 5'd31, 5'd30, 3'b001);
        prog[37] = btype(13'h0008, 5'd0, 5'd0, 3'b000);
        prog[38] = itype(12'h063, 5'd0, 3'b000, 5'd30);
        prog[39] = btype(13'h0000, 5'd0, 5'd0, 3'b000);
        for (int i = 0; i < 40; i++) dut.rom[i] = prog[i];
        for (int i = 40; i < 64; i++) dut.rom[i] = 32'h0;

        #2;
        checkReg("reset_pc", 5'd0, 32'h0);
        checkReg("reset_x5", 5'd5, 32'h0);

        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (60) @(posedge clk_in);
        @(negedge clk_in);

        checkReg("x1_load", 5'd1, 32'hB92F04A1);
        checkReg("x2_load", 5'd2, 32'h40AC8810);
        checkReg("andn", 5'd3, ZBB ? 32'hB90304A1 : 32'h0);
        checkReg("orn", 5'd4, ZBB ? 32'hBF7F77EF : 32'h0);
        checkReg("xnor", 5'd5, ZBB ? 32'h067C734E : 32'h0);
        checkReg("clz", 5'd6, ZBB ? 32'h1 : 32'h0);
        checkReg("ctz", 5'd8, ZBB ? 32'hC : 32'h0);
        checkReg("cpop", 5'd9, ZBB ? 32'hE : 32'h0);
        checkReg("clz_zero", 5'd10, ZBB ? 32'h20 : 32'h0);
        checkReg("max", 5'd11, ZBB ? 32'h40AC8810 : 32'h0);
        checkReg("maxu", 5'd12, ZBB ? 32'hB92F04A1 : 32'h0);
        checkReg("min", 5'd13, ZBB ? 32'hB92F04A1 : 32'h0);
        checkReg("minu", 5'd14, ZBB ? 32'h40AC8810 : 32'h0);
        checkReg("sext_b", 5'd15, ZBB ? 32'hFFFFFFA1 : 32'h0);
        checkReg("sext_h", 5'd16, ZBB ? 32'h000004A1 : 32'h0);
        checkReg("zext_h", 5'd17, ZBB ? 32'h000004A1 : 32'h0);
        checkReg("rev8", 5'd18, ZBB ? 32'hA1042FB9 : 32'h0);
        checkReg("orc_b", 5'd20, ZBB ? 32'h00FFFF00 : 32'h0);
        checkReg("rol", 5'd22, ZBB ? 32'h92F04A1B : 32'h0);
        checkReg("ror", 5'd23, ZBB ? 32'h1B92F04A : 32'h0);
        checkReg("rori", 5'd24, ZBB ? 32'h1B92F04A : 32'h0);
        checkReg("add_unknown_kept", 5'd25, 32'hF9DB8CB1);
        checkReg("sub", 5'd26, 32'h78827C91);
        checkReg("or", 5'd27, 32'hF9AF8CB1);
        checkReg("srl", 5'd28, 32'h0B92F04A);
        checkReg("sltu", 5'd29, 32'h1);
        checkReg("loop_count", 5'd30, 32'h3);
        checkReg("halt_pc", 5'd0, 32'h9C);

        @(negedge clk_in);
        rst_n = 1'b0;
        checkReg("midrst_pc", 5'd0, 32'h0);
        checkReg("midrst_x1", 5'd1, 32'h0);
        checkReg("midrst_x31", 5'd31, 32'h0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        checkReg("restart_pc", 5'd0, 32'h4);
        checkReg("restart_x1", 5'd1, 32'hB92F0000);
        checkReg("restart_x2", 5'd2, 32'h0);

        pat = 6'b100110;
        @(negedge clk_in);
        div_rst_n  = 1'b1;
        div_enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_in);
            #1;
            checkOutput("div_clk", {31'b0, div_clk}, {31'b0, pat[k]});
        end
        div_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_in);
            #1;
            checkOutput("div_hold", {31'b0, div_clk}, 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
